// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV32M multiply/divide unit with a start/busy/done handshake.
// Works on operand magnitudes (shift-add multiply, restoring divide) and fixes signs at the end.
// Every operation, special cases included, has the same fixed latency.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      operation,
  input  logic [XLEN-1:0] operand_1,
  input  logic [XLEN-1:0] operand_2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PREP = 2'd1;
  localparam logic [1:0] CALC = 2'd2;
  localparam logic [1:0] FIN  = 2'd3;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]        state;
  logic [2:0]        op_r;
  logic [XLEN-1:0]   a_r;
  logic [XLEN-1:0]   b_r;
  logic [XLEN-1:0]   mag;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   rem;
  logic [5:0]        count;
  logic              neg_res;
  logic              neg_rem;
  logic              div_zero;
  logic              ovf;

  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   fin_result;

  // Operand signedness per opcode and the resulting magnitudes used during PREP
  always_comb begin
    a_neg = 1'b0;
    b_neg = 1'b0;
    case (op_r)
      OP_MULH, OP_DIV, OP_REM: begin
        a_neg = a_r[XLEN-1];
        b_neg = b_r[XLEN-1];
      end
      OP_MULHSU: a_neg = a_r[XLEN-1];
      default: ;
    endcase
    mag_a = a_neg ? -a_r : a_r;
    mag_b = b_neg ? -b_r : b_r;
  end

  // One iteration of shift-add multiply and of restoring divide; the divide borrow lands in div_diff's top bit
  always_comb begin
    mul_sum   = {1'b0, prod[2*XLEN-1:XLEN]} + {1'b0, (prod[0] ? mag : {XLEN{1'b0}})};
    div_shift = {rem, prod[XLEN-1]};
    div_diff  = div_shift - {1'b0, mag};
  end

  // Sign correction and result selection, with divide-by-zero and overflow overrides
  always_comb begin
    prod_fix   = neg_res ? -prod : prod;
    quo_fix    = neg_res ? -prod[XLEN-1:0] : prod[XLEN-1:0];
    rem_fix    = neg_rem ? -rem : rem;
    fin_result = '0;
    case (op_r)
      OP_MUL:                        fin_result = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  fin_result = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               fin_result = div_zero ? {XLEN{1'b1}} : (ovf ? MOST_NEG : quo_fix);
      OP_REM, OP_REMU:               fin_result = div_zero ? a_r : (ovf ? {XLEN{1'b0}} : rem_fix);
      default:                       fin_result = '0;
    endcase
  end

  // Control FSM and datapath registers: accept, prepare, iterate 32 times, then present the result with a done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      op_r     <= '0;
      a_r      <= '0;
      b_r      <= '0;
      mag      <= '0;
      prod     <= '0;
      rem      <= '0;
      count    <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_r  <= operation;
            a_r   <= operand_1;
            b_r   <= operand_2;
            busy  <= 1'b1;
            state <= PREP;
          end
        end
        PREP: begin
          neg_res  <= a_neg ^ b_neg;
          neg_rem  <= a_neg;
          div_zero <= (b_r == '0);
          ovf      <= ((op_r == OP_DIV) || (op_r == OP_REM)) &&
                      (a_r == MOST_NEG) && (b_r == {XLEN{1'b1}});
          count    <= 6'd31;
          rem      <= '0;
          if (op_r[2]) begin
            mag  <= mag_b;
            prod <= {{XLEN{1'b0}}, mag_a};
          end else begin
            mag  <= mag_a;
            prod <= {{XLEN{1'b0}}, mag_b};
          end
          state <= CALC;
        end
        CALC: begin
          if (op_r[2]) begin
            prod[XLEN-1:0] <= {prod[XLEN-2:0], ~div_diff[XLEN]};
            rem            <= div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
          end else begin
            prod <= {mul_sum, prod[XLEN-1:1]};
          end
          if (count == 6'd0) begin
            state <= FIN;
          end else begin
            count <= count - 6'd1;
          end
        end
        FIN: begin
          if (!done) begin
            result <= fin_result;
            done   <= 1'b1;
          end else begin
            done  <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
